// File: rtl/axi_xbar_pkg.sv
// Shared AXI write-side types and constants for the crossbar slave-port logic.
package axi_xbar_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master
// that did not win last time. Purely combinational.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt
);

    always_comb begin
        o_gnt = i_last;
        case (i_req)
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = ~i_last;
            default: o_gnt = i_last;
        endcase
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 slave write port (AW/W/B) between masters m0 and m1, one
// transaction at a time, holding the grant from AW accept through the B handshake.
module axi_wr_arbiter
    import axi_xbar_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 64,
    parameter  int ID_W   = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic [ID_W-1:0]   m0_awid,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [7:0]        m0_awlen,
    input  logic [2:0]        m0_awsize,
    input  logic [1:0]        m0_awburst,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic [ID_W-1:0]   m0_bid,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,

    input  logic [ID_W-1:0]   m1_awid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [7:0]        m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [ID_W-1:0]   m1_bid,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,

    output logic [ID_W-1:0]   s0_awid,
    output logic [ADDR_W-1:0] s0_awaddr,
    output logic [7:0]        s0_awlen,
    output logic [2:0]        s0_awsize,
    output logic [1:0]        s0_awburst,
    output logic              s0_awvalid,
    input  logic              s0_awready,
    output logic [DATA_W-1:0] s0_wdata,
    output logic [STRB_W-1:0] s0_wstrb,
    output logic              s0_wlast,
    output logic              s0_wvalid,
    input  logic              s0_wready,
    input  logic [ID_W-1:0]   s0_bid,
    input  logic [1:0]        s0_bresp,
    input  logic              s0_bvalid,
    output logic              s0_bready,

    output logic              grant,
    output logic              busy,
    output logic              wlast_err
);

    wr_state_e   r_state;
    wr_state_e   w_state_nxt;
    logic        r_grant;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;

    logic        w_arb_gnt;
    logic        w_any_req;
    logic        w_sel;
    logic        w_awvalid_g;
    logic        w_wvalid_g;
    logic        w_bready_g;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;

    rr_arb2 u_rr_arb2 (
        .i_req  ({m1_awvalid, m0_awvalid}),
        .i_last (r_grant),
        .o_gnt  (w_arb_gnt)
    );

    // Payloads follow m0 while idle so the slave port never sees floating values.
    assign w_sel      = (r_state == WR_IDLE) ? 1'b0 : r_grant;
    assign w_any_req  = m0_awvalid | m1_awvalid;

    assign s0_awid    = w_sel ? m1_awid    : m0_awid;
    assign s0_awaddr  = w_sel ? m1_awaddr  : m0_awaddr;
    assign s0_awlen   = w_sel ? m1_awlen   : m0_awlen;
    assign s0_awsize  = w_sel ? m1_awsize  : m0_awsize;
    assign s0_awburst = w_sel ? m1_awburst : m0_awburst;
    assign s0_wdata   = w_sel ? m1_wdata   : m0_wdata;
    assign s0_wstrb   = w_sel ? m1_wstrb   : m0_wstrb;
    assign s0_wlast   = w_sel ? m1_wlast   : m0_wlast;

    assign w_awvalid_g = r_grant ? m1_awvalid : m0_awvalid;
    assign w_wvalid_g  = r_grant ? m1_wvalid  : m0_wvalid;
    assign w_bready_g  = r_grant ? m1_bready  : m0_bready;

    assign w_aw_hs = (r_state == WR_ADDR) && w_awvalid_g && s0_awready;
    assign w_w_hs  = (r_state == WR_DATA) && w_wvalid_g  && s0_wready;
    assign w_b_hs  = (r_state == WR_RESP) && s0_bvalid   && w_bready_g;

    assign m0_bid   = s0_bid;
    assign m1_bid   = s0_bid;
    assign m0_bresp = s0_bresp;
    assign m1_bresp = s0_bresp;

    assign grant     = r_grant;
    assign busy      = (r_state != WR_IDLE);
    assign wlast_err = w_w_hs && (s0_wlast != (r_cnt == r_len));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A missing wlast lets the beat counter wrap; only wlast ends the burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant <= 1'b1;
            r_len   <= 8'd0;
            r_cnt   <= 8'd0;
        end else begin
            if ((r_state == WR_IDLE) && w_any_req) begin
                r_grant <= w_arb_gnt;
            end
            if (w_aw_hs) begin
                r_len <= s0_awlen;
                r_cnt <= 8'd0;
            end else if (w_w_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s0_awvalid  = 1'b0;
        s0_wvalid   = 1'b0;
        s0_bready   = 1'b0;
        m0_awready  = 1'b0;
        m1_awready  = 1'b0;
        m0_wready   = 1'b0;
        m1_wready   = 1'b0;
        m0_bvalid   = 1'b0;
        m1_bvalid   = 1'b0;
        case (r_state)
            WR_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = WR_ADDR;
                end
            end
            WR_ADDR: begin
                s0_awvalid = w_awvalid_g;
                m0_awready = ~r_grant & s0_awready;
                m1_awready =  r_grant & s0_awready;
                if (w_aw_hs) begin
                    w_state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                s0_wvalid = w_wvalid_g;
                m0_wready = ~r_grant & s0_wready;
                m1_wready =  r_grant & s0_wready;
                if (w_w_hs && s0_wlast) begin
                    w_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                s0_bready = w_bready_g;
                m0_bvalid = ~r_grant & s0_bvalid;
                m1_bvalid =  r_grant & s0_bvalid;
                if (w_b_hs) begin
                    w_state_nxt = WR_IDLE;
                end
            end
            default: w_state_nxt = WR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: arbitration order, burst forwarding,
// backpressure, wlast checking and asynchronous reset, with hand-computed expectations.
module tb_axi_wr_arbiter;
    import axi_xbar_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic [7:0]  m0_awid, m1_awid;
    logic [31:0] m0_awaddr, m1_awaddr;
    logic [7:0]  m0_awlen, m1_awlen;
    logic [2:0]  m0_awsize, m1_awsize;
    logic [1:0]  m0_awburst, m1_awburst;
    logic        m0_awvalid, m1_awvalid;
    logic        m0_awready, m1_awready;
    logic [63:0] m0_wdata, m1_wdata;
    logic [7:0]  m0_wstrb, m1_wstrb;
    logic        m0_wlast, m1_wlast;
    logic        m0_wvalid, m1_wvalid;
    logic        m0_wready, m1_wready;
    logic [7:0]  m0_bid, m1_bid;
    logic [1:0]  m0_bresp, m1_bresp;
    logic        m0_bvalid, m1_bvalid;
    logic        m0_bready, m1_bready;

    logic [7:0]  s0_awid;
    logic [31:0] s0_awaddr;
    logic [7:0]  s0_awlen;
    logic [2:0]  s0_awsize;
    logic [1:0]  s0_awburst;
    logic        s0_awvalid, s0_awready;
    logic [63:0] s0_wdata;
    logic [7:0]  s0_wstrb;
    logic        s0_wlast, s0_wvalid, s0_wready;
    logic [7:0]  s0_bid;
    logic [1:0]  s0_bresp;
    logic        s0_bvalid, s0_bready;

    logic        grant, busy, wlast_err;

    int compared   = 0;
    int mismatched = 0;
    int hsCount    = 0;

    axi_wr_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
        .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
        .m0_bready(m0_bready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
        .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
        .m1_bready(m1_bready),
        .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
        .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(s0_wready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_bready(s0_bready),
        .grant(grant), .busy(busy), .wlast_err(wlast_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (s0_wvalid && s0_wready) hsCount++;
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE; drives the request mask, expects master expG to win and its AW to be accepted.
    task automatic awPhase(input logic [1:0] req, input logic expG, input logic [7:0] len);
        m0_awvalid = req[0];
        m1_awvalid = req[1];
        m0_awlen   = len;
        m1_awlen   = len;
        #1;
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_awvalid", 64'(s0_awvalid), 64'd0);
        tick;
        checkOutput("aw_grant", 64'(grant), 64'(expG));
        checkOutput("aw_valid", 64'(s0_awvalid), 64'd1);
        checkOutput("aw_addr", 64'(s0_awaddr), expG ? 64'h8000_2000 : 64'h0000_1000);
        checkOutput("aw_id", 64'(s0_awid), expG ? 64'h22 : 64'h11);
        checkOutput("aw_len", 64'(s0_awlen), 64'(len));
        checkOutput("aw_size", 64'(s0_awsize), expG ? 64'd2 : 64'd3);
        checkOutput("aw_burst", 64'(s0_awburst), expG ? 64'(AXI_BURST_WRAP) : 64'(AXI_BURST_INCR));
        checkOutput("aw_ready_g", 64'(expG ? m1_awready : m0_awready), 64'd1);
        checkOutput("aw_ready_o", 64'(expG ? m0_awready : m1_awready), 64'd0);
        tick;
        if (expG) m1_awvalid = 1'b0;
        else      m0_awvalid = 1'b0;
    endtask

    task automatic wBeat(input logic g, input logic [63:0] data, input logic last, input logic expErr);
        if (g) begin
            m1_wvalid = 1'b1; m1_wdata = data;  m1_wlast = last;
            m0_wdata  = ~data; m0_wlast = ~last;
        end else begin
            m0_wvalid = 1'b1; m0_wdata = data;  m0_wlast = last;
            m1_wdata  = ~data; m1_wlast = ~last;
        end
        #1;
        checkOutput("w_valid", 64'(s0_wvalid), 64'd1);
        checkOutput("w_data", s0_wdata, data);
        checkOutput("w_strb", 64'(s0_wstrb), g ? 64'h0F : 64'hFF);
        checkOutput("w_last", 64'(s0_wlast), 64'(last));
        checkOutput("w_ready_g", 64'(g ? m1_wready : m0_wready), 64'd1);
        checkOutput("w_ready_o", 64'(g ? m0_wready : m1_wready), 64'd0);
        checkOutput("w_awready", 64'(m0_awready | m1_awready), 64'd0);
        checkOutput("wlast_err", 64'(wlast_err), 64'(expErr));
        tick;
        m0_wvalid = 1'b0;
        m1_wvalid = 1'b0;
    endtask

    task automatic bPhase(input logic g, input logic [7:0] id, input logic [1:0] resp);
        s0_bvalid = 1'b1;
        s0_bid    = id;
        s0_bresp  = resp;
        m0_bready = 1'b1;
        m1_bready = 1'b1;
        #1;
        checkOutput("b_valid_g", 64'(g ? m1_bvalid : m0_bvalid), 64'd1);
        checkOutput("b_valid_o", 64'(g ? m0_bvalid : m1_bvalid), 64'd0);
        checkOutput("b_ready", 64'(s0_bready), 64'd1);
        checkOutput("b_id", 64'(g ? m1_bid : m0_bid), 64'(id));
        checkOutput("b_resp", 64'(g ? m1_bresp : m0_bresp), 64'(resp));
        checkOutput("b_busy", 64'(busy), 64'd1);
        checkOutput("b_awready", 64'(m0_awready | m1_awready), 64'd0);
        tick;
        s0_bvalid = 1'b0;
        #1;
        checkOutput("b_done_busy", 64'(busy), 64'd0);
        checkOutput("b_done_bvalid", 64'(m0_bvalid | m1_bvalid), 64'd0);
        checkOutput("b_done_grant", 64'(grant), 64'(g));
    endtask

    initial begin
        int beat;
        int start;

        aresetn    = 1'b0;
        m0_awid    = 8'h11;        m1_awid    = 8'h22;
        m0_awaddr  = 32'h0000_1000; m1_awaddr = 32'h8000_2000;
        m0_awlen   = 8'd0;         m1_awlen   = 8'd0;
        m0_awsize  = 3'd3;         m1_awsize  = 3'd2;
        m0_awburst = AXI_BURST_INCR; m1_awburst = AXI_BURST_WRAP;
        m0_awvalid = 1'b0;         m1_awvalid = 1'b0;
        m0_wdata   = '0;           m1_wdata   = '0;
        m0_wstrb   = 8'hFF;        m1_wstrb   = 8'h0F;
        m0_wlast   = 1'b0;         m1_wlast   = 1'b0;
        m0_wvalid  = 1'b0;         m1_wvalid  = 1'b0;
        m0_bready  = 1'b0;         m1_bready  = 1'b0;
        s0_awready = 1'b1;
        s0_wready  = 1'b1;
        s0_bvalid  = 1'b0;
        s0_bid     = 8'h00;
        s0_bresp   = AXI_RESP_OKAY;

        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant", 64'(grant), 64'd1);
        checkOutput("rst_wlast_err", 64'(wlast_err), 64'd0);
        checkOutput("rst_s0_valid", 64'({s0_awvalid, s0_wvalid, s0_bready}), 64'd0);
        checkOutput("rst_m0_hs", 64'({m0_awready, m0_wready, m0_bvalid}), 64'd0);
        checkOutput("rst_m1_hs", 64'({m1_awready, m1_wready, m1_bvalid}), 64'd0);
        #2 aresetn = 1'b1;
        tick;

        $display("[TB] single m0 write, awlen=3");
        awPhase(2'b01, 1'b0, 8'd3);
        for (int i = 0; i < 4; i++) wBeat(1'b0, 64'hD000 + 64'(i), logic'(i == 3), 1'b0);
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);

        aresetn = 1'b0;
        #2;
        checkOutput("rst2_grant", 64'(grant), 64'd1);
        aresetn = 1'b1;
        tick;

        $display("[TB] simultaneous requests, round robin");
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = logic'(k % 2);
            awPhase(2'b11, g, 8'd0);
            wBeat(g, 64'hB0 + 64'(k), 1'b1, 1'b0);
            bPhase(g, g ? 8'h22 : 8'h11, g ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
        end
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;

        $display("[TB] slave backpressure, awlen=7");
        awPhase(2'b01, 1'b0, 8'd7);
        start = hsCount;
        beat  = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            s0_wready = c[0];
            m0_wvalid = 1'b1;
            m0_wdata  = 64'hA5A5_0000_0000_0000 | 64'(beat);
            m0_wlast  = (beat == 7);
            #1;
            if (s0_wready) begin
                checkOutput("bp_data", s0_wdata, 64'hA5A5_0000_0000_0000 | 64'(beat));
                checkOutput("bp_ready", 64'(m0_wready), 64'd1);
                checkOutput("bp_err", 64'(wlast_err), 64'd0);
            end else begin
                checkOutput("bp_stall", 64'(m0_wready), 64'd0);
            end
            tick;
            if (s0_wready) beat++;
        end
        m0_wvalid = 1'b0;
        s0_wready = 1'b1;
        checkOutput("bp_beats", 64'(hsCount - start), 64'd8);
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);

        $display("[TB] early wlast on beat 2 of 4");
        awPhase(2'b01, 1'b0, 8'd3);
        wBeat(1'b0, 64'hE0, 1'b0, 1'b0);
        wBeat(1'b0, 64'hE1, 1'b1, 1'b1);
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);

        $display("[TB] late wlast on beat 5 of 4");
        awPhase(2'b01, 1'b0, 8'd3);
        for (int i = 0; i < 5; i++) wBeat(1'b0, 64'hF0 + 64'(i), logic'(i == 4), logic'(i >= 3));
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);

        $display("[TB] m1 requests while m0 is in DATA");
        awPhase(2'b01, 1'b0, 8'd1);
        m1_awvalid = 1'b1;
        wBeat(1'b0, 64'h70, 1'b0, 1'b0);
        wBeat(1'b0, 64'h71, 1'b1, 1'b0);
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);
        awPhase(2'b10, 1'b1, 8'd0);
        wBeat(1'b1, 64'h72, 1'b1, 1'b0);
        bPhase(1'b1, 8'h22, AXI_RESP_DECERR);

        $display("[TB] reset during DATA");
        awPhase(2'b01, 1'b0, 8'd3);
        wBeat(1'b0, 64'hC0, 1'b0, 1'b0);
        m0_wvalid = 1'b1;
        m0_wdata  = 64'hC1;
        m0_wlast  = 1'b0;
        #1;
        checkOutput("mid_wvalid", 64'(s0_wvalid), 64'd1);
        #1 aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_grant", 64'(grant), 64'd1);
        checkOutput("mid_rst_s0", 64'({s0_awvalid, s0_wvalid, s0_bready}), 64'd0);
        checkOutput("mid_rst_m0", 64'({m0_awready, m0_wready, m0_bvalid}), 64'd0);
        checkOutput("mid_rst_err", 64'(wlast_err), 64'd0);
        m0_wvalid = 1'b0;
        tick;
        #2 aresetn = 1'b1;
        tick;
        awPhase(2'b01, 1'b0, 8'd0);
        wBeat(1'b0, 64'hC9, 1'b1, 1'b0);
        bPhase(1'b0, 8'h11, AXI_RESP_OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
